// File: rtl/pu_riscv_ram_pkg.sv
// Shared helpers for the pu_riscv RAM wrappers:
// lane geometry and legal read latencies.
package pu_riscv_ram_pkg;

  localparam int RDLAT_MIN = 1;
  localparam int RDLAT_MAX = 2;

  function automatic int lanes(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  function automatic bit rdlat_ok(input int rdlat);
    return (rdlat >= RDLAT_MIN) && (rdlat <= RDLAT_MAX);
  endfunction

  function automatic int lane_lsb(input int lane);
    return lane * 8;
  endfunction

  // The top lane may be narrower than a byte.
  function automatic int lane_msb(input int lane, input int dbits);
    return (lane * 8 + 7 < dbits) ? lane * 8 + 7 : dbits - 1;
  endfunction

endpackage

// File: rtl/pu_riscv_ram_be_merge.sv
// Byte-lane merge: lanes with be set take new data,
// the rest keep old data.
module pu_riscv_ram_be_merge
  import pu_riscv_ram_pkg::*;
#(
  parameter  int DBITS = 32,
  localparam int NL    = lanes(DBITS)
) (
  input  logic [DBITS-1:0] old_i,
  input  logic [DBITS-1:0] new_i,
  input  logic [NL-1:0]    be_i,
  output logic [DBITS-1:0] dat_o
);

  for (genvar l = 0; l < NL; l++) begin : g_lane
    localparam int LSB = lane_lsb(l);
    localparam int MSB = lane_msb(l, DBITS);

    assign dat_o[MSB:LSB] = be_i[l] ? new_i[MSB:LSB]
                                    : old_i[MSB:LSB];
  end

endmodule

// File: rtl/pu_riscv_ram_1r1w_pipe.sv
// Pipelined 1R1W RAM with byte enables, optional
// same-address forwarding and 1 or 2 cycle read latency.
module pu_riscv_ram_1r1w_pipe
  import pu_riscv_ram_pkg::*;
#(
  parameter  int ABITS  = 10,
  parameter  int DBITS  = 32,
  parameter  int RDLAT  = 1,
  parameter  int BYPASS = 1,
  localparam int NL     = lanes(DBITS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] din_i,
  input  logic             we_i,
  input  logic [NL-1:0]    be_i,
  input  logic [ABITS-1:0] raddr_i,
  input  logic             re_i,
  output logic [DBITS-1:0] dout_o,
  output logic             dvalid_o,
  output logic             collision_o
);

  if (!rdlat_ok(RDLAT)) begin : g_bad_rdlat
    $error("pu_riscv_ram_1r1w_pipe: RDLAT must be 1 or 2");
  end

  logic [DBITS-1:0] mem [2**ABITS];

  logic             wr_en;
  logic             rd_en;
  logic             hit;
  logic [DBITS-1:0] wmask;
  logic [DBITS-1:0] rd_raw;
  logic [DBITS-1:0] byp_dat;
  logic [DBITS-1:0] rd_dat;
  logic             s1_valid;
  logic             s1_coll;
  logic [DBITS-1:0] s1_din;
  logic [NL-1:0]    s1_be;

  assign wr_en = we_i & ~rst_i;
  assign rd_en = re_i & ~rst_i;
  assign hit   = wr_en & rd_en & (waddr_i == raddr_i);

  // Lane enables expanded to a per-bit write mask.
  pu_riscv_ram_be_merge #(
    .DBITS (DBITS)
  ) u_wmask (
    .old_i ('0),
    .new_i ('1),
    .be_i  (be_i),
    .dat_o (wmask)
  );

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < DBITS; b++) begin
        if (wmask[b]) mem[waddr_i][b] <= din_i[b];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      rd_raw <= '0;
    else if (rd_en) rd_raw <= mem[raddr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      s1_din   <= '0;
      s1_be    <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_coll <= hit;
        s1_din  <= din_i;
        s1_be   <= be_i;
      end
    end
  end

  pu_riscv_ram_be_merge #(
    .DBITS (DBITS)
  ) u_bypass (
    .old_i (rd_raw),
    .new_i (s1_din),
    .be_i  (s1_be),
    .dat_o (byp_dat)
  );

  assign rd_dat = ((BYPASS != 0) && s1_coll) ? byp_dat
                                             : rd_raw;

  if (RDLAT == 1) begin : g_lat1
    assign dout_o      = rd_dat;
    assign dvalid_o    = s1_valid;
    assign collision_o = s1_valid & s1_coll;
  end else begin : g_lat2
    logic [DBITS-1:0] s2_dat;
    logic             s2_valid;
    logic             s2_coll;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2_dat   <= '0;
        s2_valid <= 1'b0;
        s2_coll  <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_dat  <= rd_dat;
          s2_coll <= s1_coll;
        end
      end
    end

    assign dout_o      = s2_dat;
    assign dvalid_o    = s2_valid;
    assign collision_o = s2_valid & s2_coll;
  end

endmodule

// File: tb/tb_pu_riscv_ram_1r1w_pipe.sv
// Directed bench: four RAM variants driven by one
// shared stimulus stream.
module tb_pu_riscv_ram_1r1w_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  waddr;
  logic [35:0] din;
  logic        we;
  logic [4:0]  be;
  logic [9:0]  raddr;
  logic        re;

  logic [31:0] a_dout, b_dout, d_dout;
  logic [35:0] c_dout;
  logic        a_dv, b_dv, c_dv, d_dv;
  logic        a_co, b_co, c_co, d_co;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pu_riscv_ram_1r1w_pipe u_dut_a (
    .clk_i (clk), .rst_i (rst),
    .waddr_i (waddr), .din_i (din[31:0]),
    .we_i (we), .be_i (be[3:0]),
    .raddr_i (raddr), .re_i (re),
    .dout_o (a_dout), .dvalid_o (a_dv),
    .collision_o (a_co)
  );

  pu_riscv_ram_1r1w_pipe #(.BYPASS(0)) u_dut_b (
    .clk_i (clk), .rst_i (rst),
    .waddr_i (waddr), .din_i (din[31:0]),
    .we_i (we), .be_i (be[3:0]),
    .raddr_i (raddr), .re_i (re),
    .dout_o (b_dout), .dvalid_o (b_dv),
    .collision_o (b_co)
  );

  pu_riscv_ram_1r1w_pipe #(.DBITS(36)) u_dut_c (
    .clk_i (clk), .rst_i (rst),
    .waddr_i (waddr), .din_i (din),
    .we_i (we), .be_i (be),
    .raddr_i (raddr), .re_i (re),
    .dout_o (c_dout), .dvalid_o (c_dv),
    .collision_o (c_co)
  );

  pu_riscv_ram_1r1w_pipe #(.RDLAT(2)) u_dut_d (
    .clk_i (clk), .rst_i (rst),
    .waddr_i (waddr), .din_i (din[31:0]),
    .we_i (we), .be_i (be[3:0]),
    .raddr_i (raddr), .re_i (re),
    .dout_o (d_dout), .dvalid_o (d_dv),
    .collision_o (d_co)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a,
                    input logic [35:0] d,
                    input logic [4:0] e);
    we = 1'b1; waddr = a; din = d; be = e;
  endtask

  task automatic rd(input logic [9:0] a);
    re = 1'b1; raddr = a;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; din = '0; be = '0;
    @(negedge clk);
    step(); step();
    check("rst_a_dout", a_dout, 0);
    check("rst_a_dv", a_dv, 0);
    check("rst_a_co", a_co, 0);
    check("rst_d_dout", d_dout, 0);
    check("rst_d_dv", d_dv, 0);

    // basic write then RDLAT=1 / RDLAT=2 read
    rst = 1'b0;
    wr(10'd5, 36'h0_DEADBEEF, 5'h0F); step();
    idle(); rd(10'd5); step();
    check("rd1_dout", a_dout, 32'hDEADBEEF);
    check("rd1_dv", a_dv, 1);
    check("rd2_dv_early", d_dv, 0);
    idle(); step();
    check("rd1_dv_drop", a_dv, 0);
    check("rd1_hold", a_dout, 32'hDEADBEEF);
    check("rd2_dv", d_dv, 1);
    check("rd2_dout", d_dout, 32'hDEADBEEF);

    // collision, forwarding vs read-first
    wr(10'd5, 36'h0_11223344, 5'h0F); step();
    idle();
    wr(10'd5, 36'h0_AABBCCDD, 5'h03); rd(10'd5); step();
    check("col_byp_dout", a_dout, 32'h1122CCDD);
    check("col_byp_co", a_co, 1);
    check("col_old_dout", b_dout, 32'h11223344);
    check("col_old_co", b_co, 1);
    idle(); step();
    check("col_a_co_drop", a_co, 0);
    check("col_d_dv", d_dv, 1);
    check("col_d_dout", d_dout, 32'h1122CCDD);
    check("col_d_co", d_co, 1);
    rd(10'd5); step();
    check("post_col_a", a_dout, 32'h1122CCDD);
    check("post_col_b", b_dout, 32'h1122CCDD);
    check("post_col_b_co", b_co, 0);

    // full-width address compare: 517 must not alias 5
    idle();
    wr(10'd517, 36'h0_55555555, 5'h0F); rd(10'd5); step();
    check("alias_dout", a_dout, 32'h1122CCDD);
    check("alias_co", a_co, 0);
    idle(); rd(10'd517); step();
    check("alias_517", a_dout, 32'h55555555);
    rd(10'd5); step();
    check("alias_5", a_dout, 32'h1122CCDD);

    // 36-bit word, narrow top lane
    idle(); wr(10'd0, 36'h0_00000000, 5'h1F); step();
    wr(10'd0, 36'hF_00000000, 5'h10); step();
    idle(); rd(10'd0); step();
    check("top_lane_0", c_dout, 36'hF_00000000);
    check("top_lane_dv", c_dv, 1);
    idle(); wr(10'd1, 36'h0_12345678, 5'h1F); step();
    wr(10'd1, 36'hF_00000000, 5'h10); step();
    idle(); rd(10'd1); step();
    check("top_lane_1", c_dout, 36'hF_12345678);

    // RDLAT=2 back-to-back reads, later write ignored
    idle(); wr(10'd1, 36'h0_000000A1, 5'h0F); step();
    wr(10'd2, 36'h0_000000A2, 5'h0F); step();
    wr(10'd3, 36'h0_000000A3, 5'h0F); step();
    idle(); rd(10'd1); step();
    check("pipe_a1", a_dout, 32'hA1);
    check("pipe_d_dv0", d_dv, 0);
    rd(10'd2); wr(10'd1, 36'h0_000000BB, 5'h0F); step();
    check("pipe_d1_dv", d_dv, 1);
    check("pipe_d1", d_dout, 32'hA1);
    check("pipe_d1_co", d_co, 0);
    check("pipe_a2", a_dout, 32'hA2);
    idle(); rd(10'd3); step();
    check("pipe_d2_dv", d_dv, 1);
    check("pipe_d2", d_dout, 32'hA2);
    idle(); step();
    check("pipe_d3_dv", d_dv, 1);
    check("pipe_d3", d_dout, 32'hA3);
    step();
    check("pipe_d_end_dv", d_dv, 0);
    check("pipe_d_hold", d_dout, 32'hA3);

    // reset with a read in flight
    rd(10'd2); step();
    idle(); rst = 1'b1;
    wr(10'd2, 36'h0_000000FF, 5'h0F); rd(10'd3); step();
    check("rst_fl_d_dv", d_dv, 0);
    check("rst_fl_d_dout", d_dout, 0);
    check("rst_fl_a_dv", a_dv, 0);
    check("rst_fl_a_dout", a_dout, 0);
    rst = 1'b0; idle(); step();
    check("rst_rel_d_dv", d_dv, 0);
    check("rst_rel_a_dv", a_dv, 0);
    step();
    check("rst_rel2_d_dv", d_dv, 0);
    rd(10'd2); step();
    check("rst_mem_a", a_dout, 32'hA2);
    idle(); step();
    check("rst_mem_d_dv", d_dv, 1);
    check("rst_mem_d", d_dout, 32'hA2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
